// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the packet-aware stream multiplexer.
package stream_mux_pkg;

    // Arbitration policy used while no packet holds the output.
    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Packet-lock state of the multiplexer.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int sel_width(input int n);
        return ($clog2(n) > 0) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: round-robin from a pointer, or fixed lowest-index
// priority. Both modes share one double-width masked priority search.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int ARB_MODE = 0,
    localparam int SEL_W    = sel_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_grant,
    output logic             o_grant_valid
);

    logic [N-1:0]   w_mask;
    logic [2*N-1:0] w_req_dbl;

    // Keep only requests at or above the pointer in the low half; fixed mode masks all.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_mask[k] = (ARB_MODE == int'(ARB_RR)) && (k >= int'(i_ptr));
        end
        w_req_dbl = {i_req, i_req & w_mask};
    end

    // Lowest set bit of the doubled vector; the upper half supplies the wrap.
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        o_grant       = '0;
        o_grant_valid = 1'b0;
        for (int j = 2*N-1; j >= 0; j--) begin
            if (w_req_dbl[j]) begin
                o_grant_valid = 1'b1;
                o_grant       = (j >= N) ? SEL_W'(j - N) : SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream multiplexer with packet locking and a
// registered output stage sustaining one beat per clock.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH      = 8,
    parameter  int NUM_INPUTS = 4,
    parameter  int ARB_MODE   = 0,
    localparam int SEL_W      = sel_width(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] in_valid,
    input  logic [WIDTH-1:0]      in_data [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0] in_last,
    output logic [NUM_INPUTS-1:0] in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    state_e           r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_lock;

    logic [SEL_W-1:0] w_arb_grant;
    logic             w_arb_valid;
    logic [SEL_W-1:0] w_grant;
    logic             w_grant_valid;
    logic             w_load_en;
    logic             w_accept;
    logic             w_accept_last;
    logic [SEL_W-1:0] w_ptr_next;

    rr_arbiter #(
        .N        (NUM_INPUTS),
        .ARB_MODE (ARB_MODE)
    ) u_arbiter (
        .i_req         (in_valid),
        .i_ptr         (r_ptr),
        .o_grant       (w_arb_grant),
        .o_grant_valid (w_arb_valid)
    );

    assign w_load_en = !out_valid || out_ready;

    // Grant follows the arbiter while idle and is pinned to the locked channel mid-packet.
    always_comb begin
        if (r_state == ST_LOCKED) begin
            w_grant       = r_lock;
            w_grant_valid = in_valid[r_lock];
        end else begin
            w_grant       = w_arb_grant;
            w_grant_valid = w_arb_valid;
        end
    end

    // At most one ready, and only when the output register can take a beat.
    always_comb begin
        in_ready = '0;
        if (w_load_en && w_grant_valid) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept      = w_load_en && w_grant_valid;
    assign w_accept_last = in_last[w_grant];
    // Wrap by compare so a non-power-of-2 channel count never yields an out-of-range pointer.
    assign w_ptr_next    = (w_grant == SEL_W'(NUM_INPUTS - 1)) ? '0 : w_grant + 1'b1;

    // Output register: load on an accepted beat, drain when the consumer takes it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (w_load_en) begin
            out_valid <= w_accept;
            if (w_accept) begin
                out_data <= in_data[w_grant];
                out_last <= w_accept_last;
                out_sel  <= w_grant;
            end
        end
    end

    // Packet lock FSM and round-robin pointer, both advanced only by accepted beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_lock  <= '0;
        end else if (w_accept) begin
            if (w_accept_last) begin
                r_state <= ST_IDLE;
                r_ptr   <= w_ptr_next;
            end else begin
                r_state <= ST_LOCKED;
                r_lock  <= w_grant;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench: randomized scoreboard run on a 4-channel round-robin
// mux, plus directed runs on a 3-channel round-robin and a 4-channel fixed mux.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int W  = 8;
    localparam int NA = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUT A: 4 channels, round-robin ----------------
    logic          a_reset;
    logic [NA-1:0] a_in_valid, a_in_last, a_in_ready;
    logic [W-1:0]  a_in_data [NA];
    logic          a_out_valid, a_out_last, a_out_ready;
    logic [W-1:0]  a_out_data;
    logic [1:0]    a_out_sel;

    stream_mux_rr #(.WIDTH(W), .NUM_INPUTS(NA), .ARB_MODE(0)) u_a (
        .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_last(a_in_last), .in_ready(a_in_ready), .out_valid(a_out_valid),
        .out_data(a_out_data), .out_last(a_out_last), .out_sel(a_out_sel),
        .out_ready(a_out_ready)
    );

    // ---------------- DUT B: 3 channels, round-robin ----------------
    logic         b_reset;
    logic [2:0]   b_in_valid, b_in_last, b_in_ready;
    logic [W-1:0] b_in_data [3];
    logic         b_out_valid, b_out_last, b_out_ready;
    logic [W-1:0] b_out_data;
    logic [1:0]   b_out_sel;

    stream_mux_rr #(.WIDTH(W), .NUM_INPUTS(3), .ARB_MODE(0)) u_b (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_last(b_in_last), .in_ready(b_in_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .out_last(b_out_last), .out_sel(b_out_sel),
        .out_ready(b_out_ready)
    );

    // ---------------- DUT C: 4 channels, fixed priority ----------------
    logic          c_reset;
    logic [NA-1:0] c_in_valid, c_in_last, c_in_ready;
    logic [W-1:0]  c_in_data [NA];
    logic          c_out_valid, c_out_last, c_out_ready;
    logic [W-1:0]  c_out_data;
    logic [1:0]    c_out_sel;

    stream_mux_rr #(.WIDTH(W), .NUM_INPUTS(NA), .ARB_MODE(1)) u_c (
        .clk(clk), .reset(c_reset), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_last(c_in_last), .in_ready(c_in_ready), .out_valid(c_out_valid),
        .out_data(c_out_data), .out_last(c_out_last), .out_sel(c_out_sel),
        .out_ready(c_out_ready)
    );

    // ---------------- Scoreboard for DUT A ----------------
    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic [1:0]   sel;
    } beat_t;

    beat_t exp_q[$];

    // Monitor: the output register holds exactly the oldest accepted, unconsumed beat.
    initial begin
        logic         prev_hold = 1'b0;
        logic [W-1:0] prev_data = '0;
        logic [1:0]   prev_sel  = '0;
        beat_t        e;
        forever begin
            @(negedge clk);
            #1;
            check("a_out_valid", 32'(a_out_valid), 32'(exp_q.size() != 0));
            if (prev_hold) begin
                check("a_hold_data", 32'(a_out_data), 32'(prev_data));
                check("a_hold_sel", 32'(a_out_sel), 32'(prev_sel));
            end
            if (a_out_valid && a_out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("a_out_data", 32'(a_out_data), 32'(e.data));
                check("a_out_last", 32'(a_out_last), 32'(e.last));
                check("a_out_sel", 32'(a_out_sel), 32'(e.sel));
            end
            prev_hold = a_out_valid && !a_out_ready;
            prev_data = a_out_data;
            prev_sel  = a_out_sel;
        end
    end

    // Reference model: packet owner plus next-search start, from the arbitration rules.
    int owner = -1;
    int ptr   = 0;
    int rem [NA];
    bit acc [NA];

    // Stimulus knobs.
    int p_start    = 0;   // % chance an idle channel begins a new packet
    int p_valid    = 100; // % chance a pending beat is offered this cycle
    int p_ready    = 100; // % chance consumer is ready
    int plen_max   = 1;
    int data_mode  = 0;   // 0 random, 1 8'hA0+ch, 2 8'h5A
    bit check_idle = 1'b0;

    task automatic run_a(input int cycles);
        int            g;
        bit            room;
        logic [NA-1:0] exp_ready;
        beat_t         b;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NA; i++) begin
                if (acc[i]) a_in_valid[i] = 1'b0;
                if (!a_in_valid[i]) begin
                    if (rem[i] == 0 && $urandom_range(99) < p_start)
                        rem[i] = $urandom_range(plen_max, 1);
                    if (rem[i] > 0 && $urandom_range(99) < p_valid) begin
                        a_in_valid[i] = 1'b1;
                        a_in_last[i]  = (rem[i] == 1);
                        a_in_data[i]  = (data_mode == 1) ? W'(8'hA0 + i) :
                                        (data_mode == 2) ? 8'h5A : W'($urandom);
                    end
                end
            end
            a_out_ready = ($urandom_range(99) < p_ready);
            #2;
            // Output slot is free iff nothing accepted earlier will still sit in it.
            room = (exp_q.size() == 0);
            g = -1;
            if (owner >= 0) begin
                if (a_in_valid[owner]) g = owner;
            end else begin
                for (int k = 0; k < NA; k++) begin
                    if (g < 0 && a_in_valid[(ptr + k) % NA]) g = (ptr + k) % NA;
                end
            end
            exp_ready = '0;
            if (room && g >= 0) exp_ready[g] = 1'b1;
            check("a_in_ready", 32'(a_in_ready), 32'(exp_ready));
            if (check_idle) check("a_idle_out_data", 32'(a_out_data), 32'h0);
            for (int i = 0; i < NA; i++) acc[i] = a_in_valid[i] && a_in_ready[i];
            if (exp_ready != 0) begin
                b.data = a_in_data[g];
                b.last = a_in_last[g];
                b.sel  = 2'(g);
                exp_q.push_back(b);
                rem[g]--;
                if (a_in_last[g]) begin
                    owner = -1;
                    ptr   = (g + 1) % NA;
                end else begin
                    owner = g;
                end
            end
        end
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        a_in_valid = '0; a_in_last = '0; a_out_ready = 1'b1;
        b_in_valid = '0; b_in_last = '0; b_out_ready = 1'b1;
        c_in_valid = '0; c_in_last = '0; c_out_ready = 1'b1;
        for (int i = 0; i < NA; i++) begin
            a_in_data[i] = '0; c_in_data[i] = '0; rem[i] = 0; acc[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) b_in_data[i] = '0;
        repeat (3) @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

        // Idle after reset: nothing offered, nothing produced, data stays zero.
        check_idle = 1'b1;
        run_a(10);
        check_idle = 1'b0;

        // All channels with single-beat packets: strict rotation 0,1,2,3,0...
        p_start = 100; p_valid = 100; p_ready = 100; plen_max = 1; data_mode = 1;
        run_a(9);

        // Multi-beat packets with competing channels and source gaps.
        p_start = 60; p_valid = 70; plen_max = 4; data_mode = 0;
        run_a(300);

        // Consumer stalls with constant data, then full speed again.
        p_start = 100; p_valid = 100; plen_max = 3; data_mode = 2; p_ready = 0;
        run_a(5);
        p_ready = 100;
        run_a(10);

        // Mixed backpressure and random traffic.
        p_start = 50; p_valid = 80; plen_max = 5; p_ready = 60; data_mode = 0;
        run_a(600);

        @(negedge clk);
        a_in_valid = '0; a_out_ready = 1'b1;

        // ---- DUT B: 3 channels, pointer wraps 2 -> 0 ----
        b_in_last = 3'b111;
        b_in_valid = 3'b010; b_in_data[1] = 8'h11;
        #1 check("b_ready_ch1", 32'(b_in_ready), 32'h2);
        @(negedge clk);
        b_in_valid = 3'b101; b_in_data[0] = 8'h20; b_in_data[2] = 8'h22;
        #1;
        check("b_out_sel_1", 32'(b_out_sel), 32'h1);
        check("b_out_data_1", 32'(b_out_data), 32'h11);
        check("b_ptr_2", 32'(u_b.r_ptr), 32'h2);
        check("b_ready_ch2", 32'(b_in_ready), 32'h4);
        @(negedge clk);
        b_in_valid = 3'b001;
        #1;
        check("b_out_sel_2", 32'(b_out_sel), 32'h2);
        check("b_out_data_2", 32'(b_out_data), 32'h22);
        check("b_ptr_wrap", 32'(u_b.r_ptr), 32'h0);
        check("b_ready_ch0", 32'(b_in_ready), 32'h1);
        @(negedge clk);
        b_in_valid = 3'b000;
        #1;
        check("b_out_sel_0", 32'(b_out_sel), 32'h0);
        check("b_out_data_0", 32'(b_out_data), 32'h20);
        check("b_ptr_1", 32'(u_b.r_ptr), 32'h1);

        // ---- DUT C: fixed priority, then reset during a ch3 packet ----
        c_in_last = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c_in_valid = 4'b1001; c_in_data[0] = W'(i); c_in_data[3] = 8'h33;
            #1;
            check("c_ready_fixed", 32'(c_in_ready), 32'h1);
            if (i > 0) begin
                check("c_out_sel_fixed", 32'(c_out_sel), 32'h0);
                check("c_out_data_fixed", 32'(c_out_data), 32'(i - 1));
            end
        end
        @(negedge clk);
        c_in_valid = 4'b1000; c_in_last = 4'b0000; c_in_data[3] = 8'h3A;
        #1 check("c_ready_ch3", 32'(c_in_ready), 32'h8);
        @(negedge clk);
        c_in_valid = 4'b1001;
        #1;
        check("c_out_valid_ch3", 32'(c_out_valid), 32'h1);
        check("c_out_sel_ch3", 32'(c_out_sel), 32'h3);
        check("c_locked", 32'(u_c.r_state), 32'(ST_LOCKED));
        check("c_lock_blocks_ch0", 32'(c_in_ready), 32'h8);
        c_reset = 1'b1;
        @(negedge clk);
        c_reset = 1'b0;
        #1;
        check("c_rst_out_valid", 32'(c_out_valid), 32'h0);
        check("c_rst_state", 32'(u_c.r_state), 32'(ST_IDLE));
        check("c_rst_ptr", 32'(u_c.r_ptr), 32'h0);
        check("c_rst_out_data", 32'(c_out_data), 32'h0);
        check("c_lock_dropped", 32'(c_in_ready), 32'h1);
        @(negedge clk);
        c_in_valid = '0;

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
